// File: rtl/gold_nic.sv
// gold_nic: network interface controller between one processing element and
// its gold_router. Memory-mapped register file (in-buf, in-status, out-buf,
// out-status) on the processor side; single-entry input and output channels
// on the router PE port, with VC/polarity-gated injection.
// Optional feature macro: NIC_SRC_STAMP_EN (stamps NODE_ID into bits [47:32]
// of every accepted out-buf write).
module gold_nic #(
    parameter logic [15:0] NODE_ID = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_polarity
);

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    logic [63:0] in_buf_r;
    logic        in_full_r;
    logic [63:0] out_buf_r;
    logic        out_full_r;
    logic [63:0] d_out_r;

    logic        rd_s;
    logic        wr_s;
    logic        capture_s;
    logic        in_clear_s;
    logic        drain_s;
    logic        out_load_s;
    logic [63:0] rd_data_s;
    logic [63:0] wr_data_s;

    // Form the packet stored on an accepted processor write.
    function automatic logic [63:0] form_out_pkt(input logic [63:0] data);
`ifdef NIC_SRC_STAMP_EN
        return {data[63:48], NODE_ID, data[31:0]};
`else
        return data;
`endif
    endfunction

    // Decode processor access and channel events for this cycle.
    always_comb begin
        rd_s       = nicEn & ~nicWrEn;
        wr_s       = nicEn & nicWrEn;
        // A new packet is only taken while the input buffer is empty.
        capture_s  = net_si & ~in_full_r;
        in_clear_s = rd_s & (addr == ADDR_IN_BUF) & in_full_r;
        // Inject only when the packet's VC matches the current ring polarity.
        drain_s    = out_full_r & net_ro & (out_buf_r[63] == net_polarity);
        // A write while the buffer is still full (even if it drains now) is dropped.
        out_load_s = wr_s & (addr == ADDR_OUT_BUF) & ~out_full_r;
        wr_data_s  = form_out_pkt(d_in);
    end

    // Select the register returned by a processor read.
    always_comb begin
        rd_data_s = 64'h0;
        case (addr)
            ADDR_IN_BUF:   rd_data_s = in_buf_r;
            ADDR_IN_STAT:  rd_data_s = {63'h0, in_full_r};
            ADDR_OUT_BUF:  rd_data_s = out_buf_r;
            ADDR_OUT_STAT: rd_data_s = {63'h0, out_full_r};
            default:       rd_data_s = 64'h0;
        endcase
    end

    // Input channel: capture from the router, release on in-buf read.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf_r  <= 64'h0;
            in_full_r <= 1'b0;
        end else if (capture_s) begin
            in_buf_r  <= net_di;
            in_full_r <= 1'b1;
        end else if (in_clear_s) begin
            in_full_r <= 1'b0;
        end else begin
            in_full_r <= in_full_r;
        end
    end

    // Output channel: load from the processor, release on injection.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_buf_r  <= 64'h0;
            out_full_r <= 1'b0;
        end else if (drain_s) begin
            out_full_r <= 1'b0;
        end else if (out_load_s) begin
            out_buf_r  <= wr_data_s;
            out_full_r <= 1'b1;
        end else begin
            out_full_r <= out_full_r;
        end
    end

    // Registered processor read data; holds when no read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out_r <= 64'h0;
        end else if (rd_s) begin
            d_out_r <= rd_data_s;
        end else begin
            d_out_r <= d_out_r;
        end
    end

    // Drive the router-facing handshake and read data.
    always_comb begin
        d_out  = d_out_r;
        net_ri = ~in_full_r;
        net_so = drain_s;
        net_do = out_buf_r;
    end

endmodule

// File: tb/tb_gold_nic.sv
// Self-checking bench for gold_nic: directed scenarios followed by
// randomized traffic, all checked against a register-level behavioural model.
module tb_gold_nic;

    localparam logic [15:0] TB_NODE_ID = 16'h0002;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'b00;
    logic [63:0] d_in = 64'h0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [63:0] net_di = 64'h0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [63:0] net_do;
    logic        net_polarity = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // model state
    logic [63:0] m_in_buf = 64'h0;
    logic        m_in_full = 1'b0;
    logic [63:0] m_out_buf = 64'h0;
    logic        m_out_full = 1'b0;
    logic [63:0] m_dout = 64'h0;
    logic        pol = 1'b0;
    logic        last_so;
    int          so_count;

    gold_nic #(.NODE_ID(TB_NODE_ID)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] stored(input logic [63:0] di);
`ifdef NIC_SRC_STAMP_EN
        return {di[63:48], TB_NODE_ID, di[31:0]};
`else
        return di;
`endif
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model, check d_out.
    task automatic step(input logic rst, input logic en, input logic we, input logic [1:0] a,
                        input logic [63:0] di, input logic si, input logic [63:0] ndi,
                        input logic ro);
        logic        exp_so;
        logic        is_rd;
        logic [63:0] nd;
        @(negedge clk);
        reset = rst; nicEn = en; nicWrEn = we; addr = a; d_in = di;
        net_si = si; net_di = ndi; net_ro = ro;
        net_polarity = pol; pol = ~pol;
        #1;
        exp_so = m_out_full && ro && (m_out_buf[63] == net_polarity);
        check_eq("net_ri", {63'h0, net_ri}, {63'h0, !m_in_full});
        check_eq("net_so", {63'h0, net_so}, {63'h0, exp_so});
        check_eq("net_do", net_do, m_out_buf);
        last_so = net_so;
        if (net_so) so_count++;
        if (rst) begin
            m_in_buf = 64'h0; m_in_full = 1'b0;
            m_out_buf = 64'h0; m_out_full = 1'b0; m_dout = 64'h0;
        end else begin
            is_rd = en && !we;
            nd = m_dout;
            if (is_rd) begin
                if (a == 2'd0) nd = m_in_buf;
                else if (a == 2'd1) nd = {63'h0, m_in_full};
                else if (a == 2'd2) nd = m_out_buf;
                else nd = {63'h0, m_out_full};
            end
            m_dout = nd;
            if (!m_in_full && si) begin
                m_in_buf = ndi; m_in_full = 1'b1;
            end else if (is_rd && a == 2'd0) begin
                m_in_full = 1'b0;
            end
            if (exp_so) m_out_full = 1'b0;
            else if (en && we && a == 2'd2 && !m_out_full) begin
                m_out_buf = stored(di); m_out_full = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("d_out", d_out, m_dout);
    endtask

    task automatic idle(input logic ro);
        step(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 64'h0, ro);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b0, 1'b1, 1'b0, a, 64'h0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] v, input logic ro);
        step(1'b0, 1'b1, 1'b1, a, v, 1'b0, 64'h0, ro);
    endtask

    initial begin
        // reset for 2 cycles
        so_count = 0;
        step(1'b1, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 64'h0, 1'b0);
        check_eq("rst_d_out", d_out, 64'h0);
        rd(2'd1);
        check_eq("rst_in_stat", d_out, 64'h0);
        rd(2'd3);
        check_eq("rst_out_stat", d_out, 64'h0);

        // inject with matching polarity
        so_count = 0;
        wr(2'd2, 64'h8000_0000_0000_00AA, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (i == 0) check_eq("inj_do", net_do, stored(64'h8000_0000_0000_00AA));
        end
        check_eq("inj_once", so_count, 1);
        rd(2'd3);
        check_eq("inj_out_stat", d_out, 64'h0);

        // backpressure and dropped second write
        so_count = 0;
        wr(2'd2, 64'h0000_0000_0000_0055, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        wr(2'd2, 64'h1, 1'b0);
        check_eq("bp_no_so", so_count, 0);
        rd(2'd2);
        check_eq("bp_keep_first", d_out, stored(64'h0000_0000_0000_0055));
        for (int i = 0; i < 3; i++) idle(1'b1);
        check_eq("bp_inject", so_count, 1);

        // receive then full input
        step(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 64'h4000_0003_0000_1234, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 64'h5555_0000_0000_0001, 1'b0);
        check_eq("rx_ri_low", {63'h0, net_ri}, 64'h0);
        rd(2'd1);
        check_eq("rx_stat", d_out, 64'h1);
        rd(2'd0);
        check_eq("rx_data", d_out, 64'h4000_0003_0000_1234);
        check_eq("rx_ri_back", {63'h0, net_ri}, 64'h1);

        // stamp / passthrough of all-ones
        wr(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`ifdef NIC_SRC_STAMP_EN
        check_eq("stamp_do", net_do, 64'hFFFF_0002_FFFF_FFFF);
`else
        check_eq("stamp_do", net_do, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        for (int i = 0; i < 3; i++) idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [63:0] rv;
            logic [63:0] rn;
            rv = {$urandom, $urandom};
            rn = {$urandom, $urandom};
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), rv,
                 $urandom_range(0, 1) == 1, rn, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
